// File: rtl/ram_march_bist.sv
// March-test BIST initiator for a single-port RAM with asynchronous read.
// Runs write P up, read P / write ~P up, read ~P down; records first failure and error count.
module ram_march_bist #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_W0   = 2'd1;
    localparam logic [1:0] S_R0W1 = 2'd2;
    localparam logic [1:0] S_R1   = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

    logic [1:0]            state, state_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic [DATA_WIDTH-1:0] pat, pat_n;
    logic                  busy_n, done_n, pass_n;
    logic [ERR_WIDTH-1:0]  err_n;
    logic [ADDR_WIDTH-1:0] fail_addr_n;
    logic [DATA_WIDTH-1:0] fail_data_n;
    logic                  mismatch_c;

    // RAM drive decodes from the state register so the write lines up with the address
    assign mem_addr = addr;
    assign mem_we   = (state == S_W0) || (state == S_R0W1);
    assign mem_d    = (state == S_W0)   ? pat  :
                      (state == S_R0W1) ? ~pat : '0;

    assign mismatch_c = ((state == S_R0W1) && (mem_q != pat)) ||
                        ((state == S_R1)   && (mem_q != ~pat));

    // Next-state and status update
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        pat_n       = pat;
        busy_n      = busy;
        done_n      = 1'b0;
        pass_n      = pass;
        err_n       = err_count;
        fail_addr_n = fail_addr;
        fail_data_n = fail_data;

        if (mismatch_c) begin
            if (err_count != ERR_MAX) err_n = err_count + ERR_WIDTH'(1);
            // err_count is zero only before the first mismatch, since it saturates
            if (err_count == '0) begin
                fail_addr_n = addr;
                fail_data_n = mem_q;
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_W0;
                    addr_n      = '0;
                    pat_n       = pattern;
                    busy_n      = 1'b1;
                    pass_n      = 1'b0;
                    err_n       = '0;
                    fail_addr_n = '0;
                    fail_data_n = '0;
                end
            end
            S_W0: begin
                if (addr == ADDR_LAST) begin
                    addr_n  = '0;
                    state_n = S_R0W1;
                end else begin
                    addr_n = addr + ADDR_WIDTH'(1);
                end
            end
            S_R0W1: begin
                if (addr == ADDR_LAST) begin
                    addr_n  = ADDR_LAST;
                    state_n = S_R1;
                end else begin
                    addr_n = addr + ADDR_WIDTH'(1);
                end
            end
            S_R1: begin
                if (addr == '0) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                end else begin
                    addr_n = addr - ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            pat       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            pat       <= pat_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_n;
            fail_addr <= fail_addr_n;
            fail_data <= fail_data_n;
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a behavioural 128x32 RAM and injectable faults.
module tb_ram_march_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] pattern;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [6:0]  fail_addr;
    logic [31:0] fail_data;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_d;
    logic [31:0] mem_q;

    int errors = 0;
    int checks = 0;
    int fault_mode = 0;   // 0 good, 1 bit3 stuck-at-0 at 0x15, 2 always zero
    int cyc;

    logic [31:0] ram [128];

    ram_march_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_d;

    always_comb begin
        mem_q = ram[mem_addr];
        if (fault_mode == 1 && mem_addr == 7'h15) mem_q = ram[mem_addr] & 32'hFFFF_FFF7;
        if (fault_mode == 2) mem_q = 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after the accepting edge; returns #1 after the edge that raises done
    task automatic wait_done(input logic [31:0] pat, input int pulse_at, output int cycles);
        cycles = 0;
        check("w0_first_we", 32'(mem_we), 32'd1);
        check("w0_first_d", mem_d, pat);
        check("w0_first_addr", 32'(mem_addr), 32'd0);
        while (cycles < 1000) begin
            if (pulse_at >= 0 && cycles == pulse_at) start = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
            if (pulse_at >= 0 && cycles == pulse_at + 1) start = 1'b0;
            if (cycles == 128) begin
                check("r0w1_d", mem_d, ~pat);
                check("r0w1_addr", 32'(mem_addr), 32'd0);
            end
            if (cycles == 256) begin
                check("r1_we", 32'(mem_we), 32'd0);
                check("r1_addr", 32'(mem_addr), 32'd127);
            end
            if (cycles == 383) check("r1_last_busy", 32'(busy), 32'd1);
            if (done) break;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_march(input logic [31:0] pat, input int pulse_at);
        @(negedge clk);
        start   = 1'b1;
        pattern = pat;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(pat, pulse_at, cyc);
        check("run_length", 32'(cyc), 32'd384);
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        pattern = 32'h0;
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_d", mem_d, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1 fault-free
        fault_mode = 0;
        run_march(32'hA5A5_A5A5, -1);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_pass_held", 32'(pass), 32'd1);
        check("t1_idle_we", 32'(mem_we), 32'd0);

        // T2 stuck-at-0 seen in R0W1
        fault_mode = 1;
        run_march(32'hFFFF_FFFF, -1);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_err", 32'(err_count), 32'd1);
        check("t2_addr", 32'(fail_addr), 32'h15);
        check("t2_data", fail_data, 32'hFFFF_FFF7);

        // T3 same fault seen only in R1
        run_march(32'h0000_0000, -1);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_err", 32'(err_count), 32'd1);
        check("t3_addr", 32'(fail_addr), 32'h15);
        check("t3_data", fail_data, 32'hFFFF_FFF7);

        // T4 reset mid-run, then clean rerun
        @(negedge clk);
        start   = 1'b1;
        pattern = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_we", 32'(mem_we), 32'd0);
        check("t4_addr", 32'(mem_addr), 32'd0);
        check("t4_d", mem_d, 32'd0);
        check("t4_err", 32'(err_count), 32'd0);
        check("t4_fail_addr", 32'(fail_addr), 32'd0);
        check("t4_fail_data", fail_data, 32'd0);
        check("t4_pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        fault_mode = 0;
        run_march(32'h1234_5678, -1);
        check("t4_rerun_pass", 32'(pass), 32'd1);

        // T5a start pulsed while busy is ignored
        run_march(32'h0F0F_0F0F, 50);
        check("t5_pass", 32'(pass), 32'd1);
        @(posedge clk); #1;
        check("t5_stay_idle", 32'(busy), 32'd0);

        // T5b start held high: one idle cycle between runs
        @(negedge clk);
        start   = 1'b1;
        pattern = 32'h5555_AAAA;
        @(posedge clk); #1;
        wait_done(32'h5555_AAAA, -1, cyc);
        check("t5b_len1", 32'(cyc), 32'd384);
        check("t5b_gap", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("t5b_restart", 32'(busy), 32'd1);
        check("t5b_done_low", 32'(done), 32'd0);
        wait_done(32'h5555_AAAA, -1, cyc);
        check("t5b_len2", 32'(cyc), 32'd384);
        check("t5b_pass", 32'(pass), 32'd1);

        // T6 read data always zero: only R0W1 compares fail (128 < 255)
        fault_mode = 2;
        run_march(32'hFFFF_FFFF, -1);
        check("t6_err", 32'(err_count), 32'h80);
        check("t6_addr", 32'(fail_addr), 32'h00);
        check("t6_data", fail_data, 32'h0);
        check("t6_pass", 32'(pass), 32'd0);

        // T6b both phases fail: 256 mismatches saturate the counter
        run_march(32'h0000_FFFF, -1);
        check("t6b_err_sat", 32'(err_count), 32'hFF);
        check("t6b_addr", 32'(fail_addr), 32'h00);
        check("t6b_data", fail_data, 32'h0);
        check("t6b_pass", 32'(pass), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
